// File: rtl/mac_multiplier_pkg.sv
// mac_pkg: shared widths and operand-splitting helpers for the MAC datapath.
package mac_pkg;
  localparam int MAC_IN_W = 16;
  localparam int MAC_PROD_W = 2 * MAC_IN_W;
  function automatic logic [63:0] mac_half_hi(input logic [63:0] v, input int hw);
    return v >> hw;
  endfunction
  function automatic logic [63:0] mac_half_lo(input logic [63:0] v, input int hw);
    return v & ((64'd1 << hw) - 64'd1);
  endfunction
endpackage

// File: rtl/mac_mul_half.sv
// mac_mul_half: combinational HW x HW unsigned multiplier, a swap point for DSP/Booth cells.
module mac_mul_half #(
  parameter int HW = 8
) (
  input  logic [HW-1:0]   a,
  input  logic [HW-1:0]   b,
  output logic [2*HW-1:0] p
);
  assign p = (2*HW)'(a) * (2*HW)'(b);
endmodule

// File: rtl/mac_multiplier.sv
// mac_multiplier: 3-stage pipelined unsigned multiplier built from four half-width partial products.
module mac_multiplier
  import mac_pkg::*;
#(
  parameter int INPUT_WIDTH = MAC_IN_W
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [INPUT_WIDTH-1:0]   i_mul_a,
  input  logic [INPUT_WIDTH-1:0]   i_mul_b,
  input  logic                     i_mul_valid,
  output logic [2*INPUT_WIDTH-1:0] o_mul_val,
  output logic                     o_mul_valid
);
  localparam int OUTPUT_WIDTH = 2 * INPUT_WIDTH;
  localparam int HW = INPUT_WIDTH / 2;
  logic [HW-1:0] a_h, a_l, b_h, b_l;
  logic [INPUT_WIDTH-1:0] p_ll, p_lh, p_hl, p_hh, q_ll, q_lh, q_hl, q_hh;
  logic [INPUT_WIDTH:0] mid;
  logic v0, v1;
  mac_mul_half #(.HW(HW)) u_ll (.a(a_l), .b(b_l), .p(q_ll));
  mac_mul_half #(.HW(HW)) u_lh (.a(a_l), .b(b_h), .p(q_lh));
  mac_mul_half #(.HW(HW)) u_hl (.a(a_h), .b(b_l), .p(q_hl));
  mac_mul_half #(.HW(HW)) u_hh (.a(a_h), .b(b_h), .p(q_hh));
  // Cross terms summed one bit wider so their carry is kept before the shift.
  assign mid = {1'b0, p_lh} + {1'b0, p_hl};
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      {a_h, a_l, b_h, b_l} <= '0;
      {p_ll, p_lh, p_hl, p_hh} <= '0;
      {v0, v1, o_mul_valid} <= '0;
      o_mul_val <= '0;
    end else begin
      a_h <= HW'(mac_half_hi(64'(i_mul_a), HW));
      a_l <= HW'(mac_half_lo(64'(i_mul_a), HW));
      b_h <= HW'(mac_half_hi(64'(i_mul_b), HW));
      b_l <= HW'(mac_half_lo(64'(i_mul_b), HW));
      v0 <= i_mul_valid;
      {p_ll, p_lh, p_hl, p_hh} <= {q_ll, q_lh, q_hl, q_hh};
      v1 <= v0;
      o_mul_val <= {p_hh, p_ll} + (OUTPUT_WIDTH'(mid) << HW);
      o_mul_valid <= v1;
    end
  end
endmodule

// File: tb/tb_mac_multiplier.sv
// tb_mac_multiplier: scoreboard bench for the pipelined multiplier.
module tb_mac_multiplier;
  localparam int W = 16;
  logic clk = 0, rst = 1, v_in = 0;
  logic [W-1:0] a = '0, b = '0;
  logic [2*W-1:0] prod;
  logic v_out;
  logic [63:0] sb[$];
  logic [2:0] vh = '0;
  int n_cmp = 0, n_bad = 0;
  mac_multiplier #(.INPUT_WIDTH(W)) dut (
    .i_clk(clk), .i_rst(rst), .i_mul_a(a), .i_mul_b(b), .i_mul_valid(v_in),
    .o_mul_val(prod), .o_mul_valid(v_out)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  task automatic cycle(input logic [W-1:0] na, input logic [W-1:0] nb, input logic nv);
    logic [63:0] e;
    @(negedge clk);
    chk("valid", {63'd0, v_out}, {63'd0, vh[2]});
    if (vh[2]) begin
      e = sb.pop_front();
      chk("prod", 64'(prod), e);
    end
    a = na; b = nb; v_in = nv;
    if (nv) sb.push_back(64'(na) * 64'(nb));
    vh = {vh[1:0], nv};
  endtask
  initial begin
    logic [6:0] gap;
    gap = 7'b1001101;
    #2;
    chk("rst_val", 64'(prod), 0);
    chk("rst_valid", {63'd0, v_out}, 0);
    @(negedge clk);
    rst = 0;
    cycle(16'h1234, 16'h5678, 1);
    chk("model_1234", sb[0], 64'h06260060);
    cycle(16'hFFFF, 16'hFFFF, 1);
    chk("model_max", sb[1], 64'hFFFE0001);
    cycle(16'h0000, 16'hBEEF, 1);
    cycle(16'hFF00, 16'h00FF, 1);
    cycle(16'h00FF, 16'h00FF, 1);
    cycle(16'hFF00, 16'hFF00, 1);
    cycle(16'h00FF, 16'hFF00, 1);
    cycle(16'hFFFF, 16'h0000, 0);
    for (int i = 0; i < 3; i++) cycle(16'h0, 16'h0, 0);
    for (int i = 1; i <= 8; i++) cycle(W'(i), W'(i + 1), 1);
    for (int i = 0; i < 3; i++) cycle(16'h0, 16'h0, 0);
    for (int i = 6; i >= 0; i--) cycle(16'hA5A5 + W'(i), 16'h3C3C, gap[i]);
    for (int i = 0; i < 4; i++) cycle(16'hDEAD, 16'hBEEF, 0);
    for (int i = 0; i < 10000; i++)
      cycle(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 3; i++) cycle(16'h1111 * W'(i + 1), 16'h7777, 1);
    @(posedge clk);
    #2;
    rst = 1;
    #1;
    chk("async_val", 64'(prod), 0);
    chk("async_valid", {63'd0, v_out}, 0);
    sb.delete();
    vh = '0;
    v_in = 0;
    @(negedge clk);
    chk("rst_hold_valid", {63'd0, v_out}, 0);
    rst = 0;
    for (int i = 0; i < 5; i++) cycle(16'h0, 16'h0, 0);
    cycle(16'hFFFF, 16'hFFFF, 1);
    for (int i = 0; i < 4; i++) cycle(16'h0, 16'h0, 0);
    chk("drain", 64'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
